// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Wishbone master that feeds the on-chip UART transmitter from a byte FIFO.
// After reset it programs the UART baud register once, then for every queued
// byte runs: write TX buffer, write start, poll status until TX done, clear
// the status flag.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   byte_i/byte_valid_i   producer byte and valid
//   byte_ready_o          FIFO has room (push = valid & ready)
//   addr_o/dat_o/dat_i    Wishbone address, write data, read data
//   we_o/sel_o/cyc_o/stb_o Wishbone control (all registered)
//   ack_i/err_i           slave acknowledge / error (err wins over ack)
//   busy_o                FSM not idle or FIFO not empty
//   err_o                 sticky error flag, cleared only by reset
//   fifo_count_o          FIFO occupancy
//   tx_count_o            bytes completed without timeout or bus error
module uart_tx_scheduler #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BAUD_DIV   = 32'h0096FEB5,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  byte_i,
  input  logic                        byte_valid_i,
  output logic                        byte_ready_o,
  output logic [31:0]                 addr_o,
  output logic [31:0]                 dat_o,
  input  logic [31:0]                 dat_i,
  output logic                        we_o,
  output logic [3:0]                  sel_o,
  output logic                        cyc_o,
  output logic                        stb_o,
  input  logic                        ack_i,
  input  logic                        err_i,
  output logic                        busy_o,
  output logic                        err_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
  output logic [15:0]                 tx_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(POLL_LIMIT) + 1;
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

  localparam logic [31:0] ADDR_CTRL  = 32'h3;
  localparam logic [31:0] ADDR_BAUD  = 32'h4;
  localparam logic [31:0] ADDR_STAT  = 32'h5;
  localparam logic [31:0] ADDR_TXBUF = 32'h7;

  typedef enum logic [2:0] {CFG, IDLE, LOAD, START, POLL, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] poll_cnt, poll_cnt_nxt;
  logic          byte_fail, byte_fail_nxt;
  logic          err_nxt;
  logic [15:0]   tx_count_nxt;
  logic [31:0]   addr_nxt, dat_nxt;
  logic          we_nxt, cyc_nxt, stb_nxt;
  logic [3:0]    sel_nxt;
  logic          push, pop;
  logic          bus_ack, bus_err;
  logic          req, req_we;
  logic [31:0]   req_addr, req_dat;
  logic          unused_dat_bits;

  assign unused_dat_bits = ^{dat_i[31:6], dat_i[4:0]};

  assign byte_ready_o = (count < CW'(FIFO_DEPTH));
  assign push         = byte_valid_i & byte_ready_o;
  assign fifo_count_o = count;
  assign busy_o       = (state != IDLE) || (count != '0);

  // A response only counts while our cycle is open; err takes priority.
  assign bus_err = cyc_o & err_i;
  assign bus_ack = cyc_o & ack_i & ~err_i;

  // Next-state and next bus-register values. Each access state requests a
  // transfer; it is launched only while cyc_o is low, which guarantees an
  // idle cycle between consecutive accesses.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_o;
    dat_nxt       = dat_o;
    we_nxt        = we_o;
    sel_nxt       = sel_o;
    cyc_nxt       = cyc_o;
    stb_nxt       = stb_o;
    poll_cnt_nxt  = poll_cnt;
    byte_fail_nxt = byte_fail;
    err_nxt       = err_o;
    tx_count_nxt  = tx_count_o;
    pop           = 1'b0;
    req           = 1'b0;
    req_we        = 1'b0;
    req_addr      = '0;
    req_dat       = '0;

    if (bus_ack || bus_err) begin
      cyc_nxt = 1'b0;
      stb_nxt = 1'b0;
    end
    if (bus_err) err_nxt = 1'b1;

    case (state)
      CFG: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = ADDR_BAUD;
        req_dat  = BAUD_DIV;
        if (bus_ack || bus_err) state_nxt = IDLE;
      end
      IDLE: begin
        if (count != '0) begin
          state_nxt     = LOAD;
          poll_cnt_nxt  = '0;
          byte_fail_nxt = 1'b0;
        end
      end
      LOAD: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = ADDR_TXBUF;
        req_dat  = {24'd0, mem[rd_ptr]};
        if (bus_ack) begin
          pop       = 1'b1;
          state_nxt = START;
        end else if (bus_err) begin
          byte_fail_nxt = 1'b1;
          state_nxt     = CLEAR;
        end
      end
      START: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = ADDR_CTRL;
        req_dat  = 32'h80;
        if (bus_ack) begin
          state_nxt = POLL;
        end else if (bus_err) begin
          byte_fail_nxt = 1'b1;
          state_nxt     = CLEAR;
        end
      end
      POLL: begin
        req      = 1'b1;
        req_addr = ADDR_STAT;
        if (bus_ack) begin
          if (dat_i[5]) begin
            state_nxt = CLEAR;
          end else begin
            poll_cnt_nxt = poll_cnt + PW'(1);
            // Timeout: flag the error but still clear the UART status.
            if (poll_cnt + PW'(1) == POLL_MAX) begin
              err_nxt       = 1'b1;
              byte_fail_nxt = 1'b1;
              state_nxt     = CLEAR;
            end
          end
        end else if (bus_err) begin
          byte_fail_nxt = 1'b1;
          state_nxt     = CLEAR;
        end
      end
      CLEAR: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = ADDR_STAT;
        req_dat  = 32'h0;
        if (bus_ack) begin
          if (!byte_fail) tx_count_nxt = tx_count_o + 16'd1;
          state_nxt = IDLE;
        end else if (bus_err) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = CFG;
    endcase

    if (req && !cyc_o) begin
      cyc_nxt  = 1'b1;
      stb_nxt  = 1'b1;
      addr_nxt = req_addr;
      dat_nxt  = req_dat;
      we_nxt   = req_we;
      sel_nxt  = 4'hF;
    end
  end

  // State, bus registers, counters and FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CFG;
      addr_o     <= '0;
      dat_o      <= '0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      err_o      <= 1'b0;
      tx_count_o <= '0;
      poll_cnt   <= '0;
      byte_fail  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      addr_o     <= addr_nxt;
      dat_o      <= dat_nxt;
      we_o       <= we_nxt;
      sel_o      <= sel_nxt;
      cyc_o      <= cyc_nxt;
      stb_o      <= stb_nxt;
      err_o      <= err_nxt;
      tx_count_o <= tx_count_nxt;
      poll_cnt   <= poll_cnt_nxt;
      byte_fail  <= byte_fail_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= byte_i;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler. A behavioural Wishbone slave
// logs every access; a transaction-level model predicts the access list,
// tx count and error flag from the bytes pushed and the slave behaviour.
module tb_uart_tx_scheduler;

  localparam int          DEPTH = 16;
  localparam int          PLIM  = 4;
  localparam logic [31:0] BAUD  = 32'h0096FEB5;

  logic        clk;
  logic        rst_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic [31:0] addr_o, dat_o, dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o, stb_o, ack_i, err_i;
  logic        busy_o, err_o;
  logic [4:0]  fifo_count_o;
  logic [15:0] tx_count_o;

  uart_tx_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .BAUD_DIV  (BAUD),
    .POLL_LIMIT(PLIM)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .byte_i      (byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .addr_o      (addr_o),
    .dat_o       (dat_o),
    .dat_i       (dat_i),
    .we_o        (we_o),
    .sel_o       (sel_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .ack_i       (ack_i),
    .err_i       (err_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .fifo_count_o(fifo_count_o),
    .tx_count_o  (tx_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] dat;
  } acc_t;

  typedef struct packed {
    logic [7:0] done_at;
    logic       err_start;
  } cfg_t;

  acc_t exp_q[$];
  acc_t got_q[$];
  cfg_t cfg_q[$];
  cfg_t cur_cfg;

  int   checks = 0;
  int   failures = 0;
  int   exp_tx = 0;
  logic exp_err = 1'b0;
  int   max_wait = 0;
  bit   stall = 1'b0;
  int   wait_cnt = 0;
  int   poll_reads = 0;
  int   n;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic acc_t mkAcc(input logic we, input logic [7:0] addr, input logic [31:0] dat);
    acc_t a;
    a.we   = we;
    a.addr = addr;
    a.dat  = dat;
    return a;
  endfunction

  // Reference model: what one byte should produce on the bus, given how the
  // slave will answer its status reads (done_at = 0 means never done).
  task automatic expectByte(input logic [7:0] b, input int done_at, input bit err_start);
    cfg_t c;
    int   reads;
    c.done_at   = 8'(done_at);
    c.err_start = err_start;
    cfg_q.push_back(c);
    exp_q.push_back(mkAcc(1'b1, 8'h07, {24'd0, b}));
    exp_q.push_back(mkAcc(1'b1, 8'h03, 32'h80));
    if (err_start) begin
      exp_err = 1'b1;
    end else begin
      reads = (done_at >= 1 && done_at <= PLIM) ? done_at : PLIM;
      for (int i = 0; i < reads; i++) exp_q.push_back(mkAcc(1'b0, 8'h05, 32'h0));
      if (done_at >= 1 && done_at <= PLIM) exp_tx++;
      else exp_err = 1'b1;
    end
    exp_q.push_back(mkAcc(1'b1, 8'h05, 32'h0));
  endtask

  // Push one byte through the valid/ready handshake; called at a negedge.
  task automatic applyStimulus(input logic [7:0] b);
    int k;
    byte_i       = b;
    byte_valid_i = 1'b1;
    k = 0;
    while (!byte_ready_o && k < 2000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("push_ready", byte_ready_o, 1);
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int done_at, input bit err_start);
    expectByte(b, done_at, err_start);
    applyStimulus(b);
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    while ((busy_o || cyc_o) && k < limit) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_reached", {busy_o, cyc_o}, 0);
  endtask

  task automatic checkLog(input string tag);
    int m;
    checkOutput({tag, "_len"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      checkOutput($sformatf("%s_acc%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Behavioural Wishbone slave with random wait states, a stall switch and
  // per-byte status behaviour taken from cfg_q when the TX buffer is written.
  always @(negedge clk) begin
    if (!cyc_o) begin
      ack_i    = 1'b0;
      err_i    = 1'b0;
      wait_cnt = int'($urandom_range(max_wait));
    end else if (stb_o && !ack_i && !err_i && !stall) begin
      if (wait_cnt > 0) begin
        wait_cnt--;
      end else begin
        checkOutput("sel", sel_o, 4'hF);
        dat_i = 32'h0;
        if (we_o && addr_o == 32'h7) begin
          if (cfg_q.size() > 0) cur_cfg = cfg_q.pop_front();
          else begin
            cur_cfg.done_at   = 8'd1;
            cur_cfg.err_start = 1'b0;
          end
          poll_reads = 0;
        end
        if (!we_o && addr_o == 32'h5) begin
          poll_reads++;
          if (cur_cfg.done_at != 0 && poll_reads == int'(cur_cfg.done_at))
            dat_i = $urandom | 32'h20;
          else
            dat_i = $urandom & ~32'h20;
        end
        got_q.push_back(mkAcc(we_o, addr_o[7:0], we_o ? dat_o : 32'h0));
        if (we_o && addr_o == 32'h3 && cur_cfg.err_start) begin
          err_i = 1'b1;
          ack_i = 1'($urandom_range(1));
        end else begin
          ack_i = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i        = 1'b1;
    byte_valid_i = 1'b0;
    byte_i       = 8'h00;
    ack_i        = 1'b0;
    err_i        = 1'b0;
    dat_i        = 32'h0;
    cur_cfg      = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    checkOutput("rst_cyc", cyc_o, 0);
    checkOutput("rst_stb", stb_o, 0);
    checkOutput("rst_addr", addr_o, 0);
    checkOutput("rst_dat", dat_o, 0);
    checkOutput("rst_we", we_o, 0);
    checkOutput("rst_sel", sel_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_fifo", fifo_count_o, 0);
    checkOutput("rst_tx", tx_count_o, 0);
    checkOutput("rst_busy", busy_o, 1);
    checkOutput("rst_ready", byte_ready_o, 1);
    rst_i = 1'b0;

    // Baud programming, then a quiet bus.
    exp_q.push_back(mkAcc(1'b1, 8'h04, BAUD));
    waitIdle(200);
    checkLog("cfg");
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (cyc_o) n++;
    end
    checkOutput("quiet_bus", n, 0);

    // Best case: zero-wait slave, done on the first read.
    max_wait = 0;
    sendByte(8'($urandom), 1, 1'b0);
    n = 0;
    while (busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("best_case_cycles", n, 9);
    checkLog("best");

    // "RAD", each finishing on the third status read.
    sendByte(8'd82, 3, 1'b0);
    sendByte(8'd65, 3, 1'b0);
    sendByte(8'd68, 3, 1'b0);
    waitIdle(2000);
    checkOutput("rad_tx", tx_count_o, exp_tx);
    checkOutput("rad_err", err_o, 0);
    checkLog("rad");

    // Stalled slave: FIFO fills, then drains in order.
    max_wait = int'($urandom_range(2));
    stall = 1'b1;
    for (int i = 0; i < 16; i++) sendByte(8'($urandom), int'($urandom_range(3, 1)), 1'b0);
    checkOutput("full_count", fifo_count_o, 16);
    checkOutput("full_ready", byte_ready_o, 0);
    repeat (5) @(negedge clk);
    checkOutput("full_ready_hold", byte_ready_o, 0);
    stall = 1'b0;
    sendByte(8'($urandom), int'($urandom_range(3, 1)), 1'b0);
    checkOutput("refill_count", fifo_count_o, 16);
    waitIdle(5000);
    checkOutput("stall_tx", tx_count_o, exp_tx);
    checkLog("stall");

    // Bus error on the START access.
    checkOutput("pre_errstart_err", err_o, 0);
    sendByte(8'($urandom), 3, 1'b1);
    waitIdle(2000);
    checkOutput("errstart_err", err_o, exp_err);
    checkOutput("errstart_tx", tx_count_o, exp_tx);
    checkOutput("errstart_fifo", fifo_count_o, 0);
    checkLog("errstart");

    // Reset while polling with three bytes still queued.
    max_wait = int'($urandom_range(2));
    for (int i = 0; i < 4; i++) sendByte(8'($urandom), (i == 0) ? 0 : 2, 1'b0);
    n = 0;
    while (!(cyc_o && !we_o && addr_o == 32'h5) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("poll_reached", {cyc_o, we_o, addr_o[7:0]}, {1'b1, 1'b0, 8'h05});
    checkOutput("queued_before_rst", fifo_count_o, 3);
    rst_i = 1'b1;
    @(negedge clk);
    checkOutput("midrst_cyc", cyc_o, 0);
    checkOutput("midrst_stb", stb_o, 0);
    checkOutput("midrst_fifo", fifo_count_o, 0);
    checkOutput("midrst_err", err_o, 0);
    checkOutput("midrst_tx", tx_count_o, 0);
    checkOutput("midrst_busy", busy_o, 1);
    rst_i = 1'b0;
    got_q.delete();
    exp_q.delete();
    cfg_q.delete();
    poll_reads = 0;
    exp_tx  = 0;
    exp_err = 1'b0;
    exp_q.push_back(mkAcc(1'b1, 8'h04, BAUD));
    waitIdle(200);
    checkLog("rst");

    // Poll timeout, then a normal byte proceeds.
    sendByte(8'($urandom), 0, 1'b0);
    sendByte(8'($urandom), int'($urandom_range(3, 1)), 1'b0);
    waitIdle(2000);
    checkOutput("timeout_err", err_o, exp_err);
    checkOutput("timeout_tx", tx_count_o, exp_tx);
    checkLog("timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
